dtc_seq: RTL and testbench
==========================

DTC_SEQ -- requirements
Module: dtc_seq

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 15, giving the maximum number of WAIT cycles before a timeout (range 1..255).
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the sample FIFO depth in entries (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_data  input  8  signed two's-complement sample.
REQ-007 in_ready  output  1  FIFO can accept a sample.
REQ-008 en  input  1  sequencer enable.
REQ-009 trig  input  1  one-cycle sample-period strobe.
REQ-010 dtc_done  input  1  DTC edge-completion pulse.
REQ-011 clr_err  input  1  clears the sticky error flags.
REQ-012 dtc_code  output  8  unsigned magnitude to the DTC.
REQ-013 dtc_sign  output  1  sign to the DTC: 1 for positive or zero, 0 for negative.
REQ-014 dtc_fire  output  1  one-cycle DTC launch pulse.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 underrun  output  1  sticky flag: trig arrived while the FIFO was empty.
REQ-017 trig_miss  output  1  sticky flag: trig arrived while busy.
REQ-018 timeout_err  output  1  sticky flag: dtc_done not received within TIMEOUT cycles.
REQ-019 fire_count  output  16  count of completed conversions.

Function
REQ-020 The FIFO SHALL accept a push when in_valid and in_ready are both high; in_ready SHALL be the negation of FIFO full.
REQ-021 The FSM SHALL have the states IDLE, LOAD, FIRE and WAIT.
REQ-022 In IDLE, when trig, en and FIFO non-empty are all high, the FSM SHALL pop the head entry and go to LOAD on that edge.
REQ-023 In LOAD, the FSM SHALL register dtc_sign = NOT in_data[7] and dtc_code = |sample|, then go to FIRE.
REQ-024 The magnitude of -128 SHALL be 0x80, and a sample of 0 SHALL give code 0x00 with sign 1.
REQ-025 In FIRE, dtc_fire SHALL be high for exactly one cycle, dtc_code and dtc_sign SHALL already be stable, and the next state SHALL be WAIT.
REQ-026 On entry to WAIT, the timeout counter SHALL be cleared.
REQ-027 In WAIT, on dtc_done the FSM SHALL go to IDLE and fire_count SHALL increment (wrapping 0xFFFF to 0x0000).
REQ-028 If the WAIT counter reaches TIMEOUT without dtc_done, the FSM SHALL set timeout_err, leave fire_count unchanged and go to IDLE.
REQ-029 If dtc_done and the timeout occur on the same cycle, dtc_done SHALL win.
REQ-030 The latency from trig to dtc_fire SHALL be 2 cycles, and the minimum spacing between successive fires SHALL be 4 cycles.
REQ-031 dtc_done SHALL be ignored outside WAIT.
REQ-032 Trig with en high in IDLE with the FIFO empty SHALL set underrun and start no conversion.
REQ-033 A sample pushed on the same cycle as trig SHALL NOT bypass the FIFO, so an empty FIFO at that edge still sets underrun.
REQ-034 Trig with en high outside IDLE SHALL set trig_miss and SHALL NOT be queued.
REQ-035 Trig with en low SHALL be ignored and SHALL set no flag.
REQ-036 Deasserting en mid-conversion SHALL NOT abort the conversion in progress.
REQ-037 A simultaneous push and pop SHALL leave the occupancy unchanged, and pointers SHALL wrap modulo DEPTH.
REQ-038 clr_err SHALL clear all sticky flags, except that a flag set on the same cycle wins over clr_err.
REQ-039 dtc_code and dtc_sign SHALL hold their values until the next LOAD.

Reset
REQ-040 While rst_n is low, the FSM SHALL be IDLE and the FIFO SHALL be empty.
REQ-041 While rst_n is low, in_ready SHALL be 1, dtc_code 0x00, dtc_sign 1, dtc_fire 0 and busy 0.
REQ-042 While rst_n is low, underrun, trig_miss and timeout_err SHALL be 0 and fire_count SHALL be 0.
REQ-043 Reset asserted mid-conversion SHALL abort immediately, discard the FIFO contents, and produce no dtc_fire after release.

Verification
REQ-044 Push 0x05, 0xFB, 0x80, 0x00; trig each, with dtc_done 3 cycles after each fire -> code/sign 05/1, 05/0, 80/0, 00/1; fire_count=4.
REQ-045 Push 5 samples back-to-back with DEPTH=4 -> in_ready low after the 4th; the 5th is held until a pop.
REQ-046 Trig with the FIFO empty, then trig during WAIT -> underrun=1, trig_miss=1, no extra fire; clr_err -> both 0.
REQ-047 Fire with dtc_done never asserted, TIMEOUT=15 -> timeout_err set 15 cycles after entering WAIT; FSM returns to IDLE; fire_count unchanged.
REQ-048 dtc_done on the exact timeout cycle -> fire_count increments and timeout_err stays 0.
REQ-049 Assert rst_n low during WAIT with 2 samples queued -> all outputs at reset values, in_ready=1, no fire after release.

Source files
------------

// File: rtl/dtc_seq.sv
// dtc_seq: sample FIFO feeding a LOAD/FIRE/WAIT sequencer that launches DTC edges,
// counts completed conversions and keeps sticky underrun/miss/timeout flags.
module dtc_seq #(
  parameter int TIMEOUT = 15,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        en,
  input  logic        trig,
  input  logic        dtc_done,
  input  logic        clr_err,
  output logic [7:0]  dtc_code,
  output logic        dtc_sign,
  output logic        dtc_fire,
  output logic        busy,
  output logic        underrun,
  output logic        trig_miss,
  output logic        timeout_err,
  output logic [15:0] fire_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];
  localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FIRE, ST_WAIT} state_t;

  state_t          state_reg;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [7:0]      sample_reg;
  logic [7:0]      wait_cnt_reg;
  logic [7:0]      code_reg;
  logic            sign_reg;
  logic            fire_reg;
  logic [15:0]     fire_count_reg;
  logic [2:0]      flag_reg, flag_set, flag_next;
  logic            full, empty, push, pop;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Only the registered occupancy is consulted, so a same-cycle push cannot bypass.
  assign pop      = (state_reg == ST_IDLE) && trig && en && !empty;

  assign flag_set[0] = (state_reg == ST_IDLE) && trig && en && empty;
  assign flag_set[1] = (state_reg != ST_IDLE) && trig && en;
  assign flag_set[2] = (state_reg == ST_WAIT) && !dtc_done && (wait_cnt_reg == TO_LAST);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag
      assign flag_next[gi] = flag_set[gi] | (flag_reg[gi] & ~clr_err);
    end
  endgenerate

  // Sample storage with registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
    if (pop)
      sample_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      wait_cnt_reg   <= '0;
      code_reg       <= 8'h00;
      sign_reg       <= 1'b1;
      fire_reg       <= 1'b0;
      fire_count_reg <= '0;
      flag_reg       <= '0;
    end else begin
      fire_reg <= 1'b0;
      flag_reg <= flag_next;

      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase

      case (state_reg)
        ST_IDLE: begin
          if (pop)
            state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          // Two's-complement magnitude; -128 naturally maps to 0x80.
          sign_reg  <= ~sample_reg[7];
          code_reg  <= sample_reg[7] ? (~sample_reg + 8'd1) : sample_reg;
          fire_reg  <= 1'b1;
          state_reg <= ST_FIRE;
        end
        ST_FIRE: begin
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dtc_done) begin
            fire_count_reg <= fire_count_reg + 16'd1;
            state_reg      <= ST_IDLE;
          end else if (wait_cnt_reg == TO_LAST) begin
            state_reg <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign dtc_code    = code_reg;
  assign dtc_sign    = sign_reg;
  assign dtc_fire    = fire_reg;
  assign fire_count  = fire_count_reg;
  assign underrun    = flag_reg[0];
  assign trig_miss   = flag_reg[1];
  assign timeout_err = flag_reg[2];

endmodule

// File: tb/tb_dtc_seq.sv
// Directed bench for dtc_seq: a scoreboard of expected code/sign pairs is filled
// on every accepted push and drained by a monitor on every dtc_fire.
module tb_dtc_seq;

  logic        clk, rst_n, in_valid, en, trig, dtc_done, clr_err;
  logic [7:0]  in_data;
  logic        in_ready, dtc_sign, dtc_fire, busy, underrun, trig_miss, timeout_err;
  logic [7:0]  dtc_code;
  logic [15:0] fire_count;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          fire_seen = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_exp;

  dtc_seq #(.TIMEOUT(15), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en(en), .trig(trig), .dtc_done(dtc_done),
    .clr_err(clr_err), .dtc_code(dtc_code), .dtc_sign(dtc_sign),
    .dtc_fire(dtc_fire), .busy(busy), .underrun(underrun),
    .trig_miss(trig_miss), .timeout_err(timeout_err), .fire_count(fire_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {sign, code}: sign 1 for >= 0, code is the absolute value.
  function automatic logic [8:0] exp_of(input logic [7:0] s);
    int v;
    v = int'($signed(s));
    return {(v >= 0) ? 1'b1 : 1'b0, 8'(v < 0 ? -v : v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s);
    check("in_ready_before_push", in_ready, 1);
    in_valid = 1'b1;
    in_data  = s;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(exp_of(s));
  endtask

  task automatic conv(input int done_delay);
    trig = 1'b1;
    en   = 1'b1;
    tick();
    trig = 1'b0;
    check("busy_after_trig", busy, 1);
    tick();
    check("fire_latency", dtc_fire, 1);
    repeat (done_delay) tick();
    dtc_done = 1'b1;
    tick();
    dtc_done = 1'b0;
    check("idle_after_done", busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && dtc_fire) begin
      fire_seen++;
      check("fire_expected", 32'(dtc_fire), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("fire_code_sign", {dtc_sign, dtc_code}, mon_exp);
        $display("fire #%0d code=%02h sign=%0b", fire_seen, dtc_code, dtc_sign);
      end
    end
  end

  initial begin
    int fs;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; en = 1'b0;
    trig = 1'b0; dtc_done = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_code", dtc_code, 8'h00);
    check("rst_sign", dtc_sign, 1);
    check("rst_fire", dtc_fire, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {underrun, trig_miss, timeout_err}, 3'b000);
    check("rst_fire_count", fire_count, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Basic conversions, including -5, -128 and zero.
    push(8'h05); push(8'hFB); push(8'h80); push(8'h00);
    for (int i = 0; i < 4; i++) begin
      conv(3);
      check("fire_count_basic", fire_count, 32'(i + 1));
    end
    check("fires_basic", fire_seen, 4);

    // Underrun, then missed trigger during WAIT.
    trig = 1'b1; en = 1'b1; tick(); trig = 1'b0;
    check("underrun_set", underrun, 1);
    check("underrun_no_conv", busy, 0);
    push(8'h7F);
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    trig = 1'b1; tick(); trig = 1'b0;
    check("trig_miss_set", trig_miss, 1);
    check("busy_in_wait", busy, 1);
    dtc_done = 1'b1; tick(); dtc_done = 1'b0;
    check("fire_count_miss", fire_count, 5);
    tick(); tick();
    check("no_extra_fire", fire_seen, 5);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_underrun", underrun, 0);
    check("clr_trig_miss", trig_miss, 0);

    // Trig with en low is ignored; a set on the clr_err cycle wins.
    en = 1'b0; trig = 1'b1; tick(); trig = 1'b0;
    check("en_low_no_flag", underrun, 0);
    check("en_low_idle", busy, 0);
    en = 1'b1; trig = 1'b1; clr_err = 1'b1; tick(); trig = 1'b0; clr_err = 1'b0;
    check("set_beats_clr", underrun, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;

    // Push on the trig cycle does not bypass an empty FIFO.
    trig = 1'b1; in_valid = 1'b1; in_data = 8'h11; tick();
    trig = 1'b0; in_valid = 1'b0;
    exp_q.push_back(exp_of(8'h11));
    check("push_trig_underrun", underrun, 1);
    check("push_trig_no_conv", busy, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_again", underrun, 0);

    // Timeout with dtc_done never asserted.
    trig = 1'b1; tick(); trig = 1'b0;
    tick();
    check("fire_latency_to", dtc_fire, 1);
    repeat (15) tick();
    check("timeout_not_yet", timeout_err, 0);
    check("busy_before_to", busy, 1);
    tick();
    check("timeout_set", timeout_err, 1);
    check("idle_after_to", busy, 0);
    check("fire_count_to", fire_count, 5);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr_timeout", timeout_err, 0);

    // dtc_done on the timeout cycle wins; en dropped mid-conversion.
    push(8'h22);
    trig = 1'b1; tick(); trig = 1'b0; en = 1'b0;
    tick();
    check("fire_en_dropped", dtc_fire, 1);
    repeat (15) tick();
    dtc_done = 1'b1; tick(); dtc_done = 1'b0;
    check("done_wins_count", fire_count, 6);
    check("done_wins_no_err", timeout_err, 0);
    check("done_wins_idle", busy, 0);
    en = 1'b1;

    // Fill past DEPTH: fifth sample held until a pop makes room.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ready_filling", in_ready, 1);
      in_data = 8'(8'h31 + 8'(i * 8'h3D));
      tick();
      exp_q.push_back(exp_of(in_data));
    end
    check("ready_full", in_ready, 0);
    in_data = 8'hC0;
    tick();
    check("fifth_held", in_ready, 0);
    trig = 1'b1; tick(); trig = 1'b0;
    check("ready_after_pop", in_ready, 1);
    tick();
    exp_q.push_back(exp_of(8'hC0));
    in_valid = 1'b0;
    check("refull", in_ready, 0);
    check("fire_full", dtc_fire, 1);
    tick();
    dtc_done = 1'b1; tick(); dtc_done = 1'b0;
    for (int i = 0; i < 4; i++) conv(2);
    check("fire_count_drain", fire_count, 11);
    check("scoreboard_drained", exp_q.size(), 0);
    check("fires_drain", fire_seen, 12);

    // Reset during WAIT with two samples still queued.
    push(8'h10); push(8'h20); push(8'h30);
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
    check("busy_pre_reset", busy, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_code", dtc_code, 8'h00);
    check("async_rst_sign", dtc_sign, 1);
    check("async_rst_fire", dtc_fire, 0);
    check("async_rst_count", fire_count, 16'h0000);
    check("async_rst_flags", {underrun, trig_miss, timeout_err}, 3'b000);
    fs = fire_seen;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("no_fire_after_rst", fire_seen, fs);
    trig = 1'b1; tick(); trig = 1'b0;
    check("fifo_discarded", underrun, 1);
    tick(); tick();
    check("no_conv_after_rst", fire_seen, fs);
    check("idle_after_rst", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
